// File: rtl/smart_cargo_sequencer_if.sv
// smart_cargo_sequencer_if: sensor/command inputs and registered control outputs of the cargo sequencer
interface smart_cargo_sequencer_if;
  logic bordaNovoDestino, chegouDestino, sobe, temDestino, eh_origem_fila, fimT, ramSecDifZero;
  logic carona_origem, carona_destino, andarRepetidoOrigem, andarRepetidoDestino;
  logic shift, enableRAM, fit, zeraT, contaT, zeraAddrSecundario, contaAddrSecundario;
  logic enableRegDestino, select1, select3, coloca_objetos, tira_objetos, inicia_ultrasonico;
  logic enableAndarAtual, motor_sobe, motor_desce, overrun, erro_fila;
  logic [3:0] db_estado;
  modport master (
    output bordaNovoDestino, chegouDestino, sobe, temDestino, eh_origem_fila, fimT, ramSecDifZero,
           carona_origem, carona_destino, andarRepetidoOrigem, andarRepetidoDestino,
    input  shift, enableRAM, fit, zeraT, contaT, zeraAddrSecundario, contaAddrSecundario,
           enableRegDestino, select1, select3, coloca_objetos, tira_objetos, inicia_ultrasonico,
           enableAndarAtual, motor_sobe, motor_desce, overrun, erro_fila, db_estado
  );
  modport slave (
    input  bordaNovoDestino, chegouDestino, sobe, temDestino, eh_origem_fila, fimT, ramSecDifZero,
           carona_origem, carona_destino, andarRepetidoOrigem, andarRepetidoDestino,
    output shift, enableRAM, fit, zeraT, contaT, zeraAddrSecundario, contaAddrSecundario,
           enableRegDestino, select1, select3, coloca_objetos, tira_objetos, inicia_ultrasonico,
           enableAndarAtual, motor_sobe, motor_desce, overrun, erro_fila, db_estado
  );
endinterface

// File: rtl/smart_cargo_sequencer.sv
// smart_cargo_sequencer: elevator cargo FSM with queue scan/insert; SMART_CARGO_CARONA_EN enables ride-share insertion.
// Control outputs are registered: each reflects the decode of the previous cycle's state and inputs.
module smart_cargo_sequencer #(
  parameter int SCAN_MAX = 15
) (
  input logic clock,
  input logic reset,
  smart_cargo_sequencer_if.slave bus
);
  typedef enum logic [3:0] {
    INICIAL = 4'h0, OCIOSO, REGISTRA, BUSCA_ORIGEM, INSERE_ORIGEM, BUSCA_DESTINO,
    INSERE_DESTINO, MEDE, MOVE, PARADA, PORTA, TROCA, AVANCA
  } state_t;
  typedef struct packed {
    logic shift, enableRAM, fit, zeraT, contaT, zeraAddrSecundario, contaAddrSecundario;
    logic enableRegDestino, select1, select3, coloca_objetos, tira_objetos, inicia_ultrasonico;
    logic enableAndarAtual, motor_sobe, motor_desce, overrun, erro_fila;
  } outs_t;
  localparam logic [3:0] SCAN_LIM = 4'(SCAN_MAX);
  state_t state, next;
  outs_t q, d;
  logic pending, pending_n, consume, origem, rep, hit;
  logic [3:0] cnt, cnt_n;
  assign origem = state == BUSCA_ORIGEM;
`ifdef SMART_CARGO_CARONA_EN
  localparam bit CARONA = 1'b1;
  assign rep = origem ? bus.andarRepetidoOrigem : bus.andarRepetidoDestino;
  assign hit = ~bus.ramSecDifZero | (origem ? bus.carona_origem : bus.carona_destino);
`else
  localparam bit CARONA = 1'b0;
  logic unused_ride;
  assign unused_ride = ^{bus.carona_origem, bus.carona_destino, bus.andarRepetidoOrigem, bus.andarRepetidoDestino};
  assign rep = 1'b0;
  assign hit = ~bus.ramSecDifZero;
`endif
  // a new destination is only consumed on the OCIOSO -> REGISTRA transition
  assign consume = state == OCIOSO && pending;
  assign pending_n = bus.bordaNovoDestino | (pending & ~consume);
  assign bus.db_estado = state;
  assign {bus.shift, bus.enableRAM, bus.fit, bus.zeraT, bus.contaT, bus.zeraAddrSecundario,
          bus.contaAddrSecundario, bus.enableRegDestino, bus.select1, bus.select3,
          bus.coloca_objetos, bus.tira_objetos, bus.inicia_ultrasonico, bus.enableAndarAtual,
          bus.motor_sobe, bus.motor_desce, bus.overrun, bus.erro_fila} = q;
  always_comb begin
    next = state;
    cnt_n = cnt;
    d = '0;
    d.overrun = bus.bordaNovoDestino & pending & ~consume;
    case (state)
      INICIAL: next = OCIOSO;
      OCIOSO: next = pending ? REGISTRA : bus.temDestino ? MEDE : OCIOSO;
      REGISTRA: begin
        d.enableRegDestino = 1'b1;
        d.zeraAddrSecundario = 1'b1;
        cnt_n = '0;
        next = BUSCA_ORIGEM;
      end
      BUSCA_ORIGEM, BUSCA_DESTINO: begin
        d.select1 = origem;
        d.select3 = cnt == '0;
        if (rep) next = origem ? BUSCA_DESTINO : OCIOSO;
        else if (hit) next = origem ? INSERE_ORIGEM : INSERE_DESTINO;
        else if (cnt == SCAN_LIM) begin
          d.erro_fila = 1'b1;
          next = OCIOSO;
        end else begin
          d.contaAddrSecundario = 1'b1;
          cnt_n = cnt == 4'hf ? cnt : cnt + 4'd1;
        end
      end
      INSERE_ORIGEM, INSERE_DESTINO: begin
        d.enableRAM = 1'b1;
        d.fit = CARONA & bus.ramSecDifZero;
        next = state == INSERE_ORIGEM ? BUSCA_DESTINO : OCIOSO;
      end
      MEDE, MOVE: begin
        d.inicia_ultrasonico = 1'b1;
        d.enableAndarAtual = 1'b1;
        d.motor_sobe = state == MOVE && bus.sobe && !bus.chegouDestino && !pending;
        d.motor_desce = state == MOVE && !bus.sobe && !bus.chegouDestino && !pending;
        next = state == MEDE ? MOVE : bus.chegouDestino ? PARADA : pending ? OCIOSO : MOVE;
      end
      PARADA: begin
        d.zeraT = 1'b1;
        next = PORTA;
      end
      PORTA: begin
        d.contaT = ~bus.fimT;
        next = bus.fimT ? TROCA : PORTA;
      end
      TROCA: begin
        d.coloca_objetos = bus.eh_origem_fila;
        d.tira_objetos = ~bus.eh_origem_fila;
        next = AVANCA;
      end
      AVANCA: begin
        d.shift = 1'b1;
        next = OCIOSO;
      end
      default: next = INICIAL;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= INICIAL;
      pending <= 1'b0;
      cnt <= '0;
      q <= '0;
    end else begin
      state <= next;
      pending <= pending_n;
      cnt <= cnt_n;
      q <= d;
    end
  end
endmodule

// File: tb/tb_smart_cargo_sequencer.sv
// tb_smart_cargo_sequencer: directed vectors for the cargo sequencer with a tiny queue/address model driving ramSecDifZero.
module tb_smart_cargo_sequencer;
  logic clk = 1'b0;
  logic reset;
  int n_tests = 0, n_fail = 0;
  int addr = 0, qlen = 0, carona_at = -1;
  int n_conta_pre, fit_first, n_ram, n_fit, n_erro;
  int cnt_a, cnt_b, cnt_c, cnt_d;
  logic [3:0] trace [8];
  smart_cargo_sequencer_if bus();
  smart_cargo_sequencer dut (.clock(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] outs();
    return {bus.shift, bus.enableRAM, bus.fit, bus.zeraT, bus.contaT, bus.zeraAddrSecundario,
            bus.contaAddrSecundario, bus.enableRegDestino, bus.select1, bus.select3,
            bus.coloca_objetos, bus.tira_objetos, bus.inicia_ultrasonico, bus.enableAndarAtual,
            bus.motor_sobe, bus.motor_desce, bus.overrun, bus.erro_fila};
  endfunction

  // secondary RAM address follows zeraAddr/contaAddr; entries below qlen are occupied
  task automatic tick();
    @(posedge clk); #1;
    if (bus.zeraAddrSecundario) addr = 0;
    else if (bus.contaAddrSecundario) addr++;
    bus.ramSecDifZero = addr < qlen;
    bus.carona_origem = addr == carona_at;
  endtask

  task automatic request(input int q, input int cat);
    qlen = q;
    carona_at = cat;
    bus.ramSecDifZero = addr < qlen;
    n_conta_pre = 0; fit_first = -1; n_ram = 0; n_fit = 0; n_erro = 0;
    bus.bordaNovoDestino = 1'b1;
    tick();
    bus.bordaNovoDestino = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i < 8) trace[i] = bus.db_estado;
      if (bus.contaAddrSecundario && n_ram == 0) n_conta_pre++;
      if (bus.enableRAM && n_ram == 0) fit_first = int'(bus.fit);
      n_ram += int'(bus.enableRAM);
      n_fit += int'(bus.fit);
      n_erro += int'(bus.erro_fila);
    end
  endtask

  initial begin
    reset = 1'b0;
    {bus.bordaNovoDestino, bus.chegouDestino, bus.sobe, bus.temDestino, bus.eh_origem_fila, bus.fimT,
     bus.ramSecDifZero, bus.carona_origem, bus.carona_destino, bus.andarRepetidoOrigem,
     bus.andarRepetidoDestino} = '0;
    tick(); tick();
    check("reset_outs", 32'(outs()), 0);
    check("reset_state", 32'(bus.db_estado), 0);
    reset = 1'b1;
    tick();
    tick();
    check("release_ocioso", 32'(bus.db_estado), 1);

    // empty queue: both inserts append at address 0
    request(0, -1);
    for (int i = 0; i < 6; i++) check($sformatf("empty_trace%0d", i), 32'(trace[i]), 32'(i == 5 ? 1 : i + 2));
    check("empty_ram_pulses", n_ram, 2);
    check("empty_fit", n_fit, 0);
    check("empty_end", 32'(bus.db_estado), 1);

    // queue of 3 with a ride-share match at scan count 2
    request(3, 2);
`ifdef SMART_CARGO_CARONA_EN
    check("carona_conta", n_conta_pre, 2);
    check("carona_fit", fit_first, 1);
`else
    check("append_conta", n_conta_pre, 3);
    check("append_fit", fit_first, 0);
`endif
    check("queue3_ram", n_ram, 2);

    // full queue, no match: scan exhausts and reports an error
    request(99, -1);
    check("full_conta", n_conta_pre, 15);
    check("full_erro", n_erro, 1);
    check("full_ram", n_ram, 0);
    check("full_end", 32'(bus.db_estado), 1);

    // travel up, stop, door, load, shift
    qlen = 0; carona_at = -1;
    bus.temDestino = 1'b1; bus.sobe = 1'b1; bus.eh_origem_fila = 1'b1;
    tick();
    check("mede_state", 32'(bus.db_estado), 7);
    bus.temDestino = 1'b0;
    tick();
    check("move_state", 32'(bus.db_estado), 8);
    check("mede_outs", 32'({bus.inicia_ultrasonico, bus.enableAndarAtual, bus.motor_sobe}), 32'b110);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      cnt_a += int'(bus.motor_sobe);
      cnt_b += int'(bus.motor_desce);
    end
    bus.chegouDestino = 1'b1;
    tick();
    cnt_a += int'(bus.motor_sobe);
    check("parada_state", 32'(bus.db_estado), 9);
    check("move_up_cycles", cnt_a, 50);
    check("move_down_never", cnt_b, 0);
    bus.chegouDestino = 1'b0;
    tick();
    check("porta_zeraT", 32'({bus.db_estado, bus.zeraT, bus.motor_sobe}), 32'({4'd10, 1'b1, 1'b0}));
    cnt_a = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cnt_a += int'(bus.contaT);
    end
    check("porta_contaT", cnt_a, 3);
    bus.fimT = 1'b1;
    tick();
    bus.fimT = 1'b0;
    check("troca_state", 32'({bus.db_estado, bus.contaT}), 32'({4'd11, 1'b0}));
    tick();
    check("coloca", 32'({bus.db_estado, bus.coloca_objetos, bus.tira_objetos}), 32'({4'd12, 2'b10}));
    tick();
    check("shift_pulse", 32'({bus.db_estado, bus.shift}), 32'({4'd1, 1'b1}));
    tick();
    check("shift_end", 32'(bus.shift), 0);

    // travel down, then two destination edges while the door is open
    bus.sobe = 1'b0; bus.eh_origem_fila = 1'b0; bus.temDestino = 1'b1;
    tick();
    bus.temDestino = 1'b0;
    tick(); tick();
    check("move_down", 32'({bus.motor_sobe, bus.motor_desce}), 32'b01);
    bus.chegouDestino = 1'b1;
    tick();
    bus.chegouDestino = 1'b0;
    tick();
    check("porta_again", 32'(bus.db_estado), 10);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    for (int i = 0; i < 30; i++) begin
      bus.bordaNovoDestino = i == 0 || i == 3;
      bus.fimT = i == 6;
      tick();
      cnt_a += int'(bus.overrun);
      cnt_b += int'(bus.db_estado == 4'd2);
      cnt_c += int'(bus.tira_objetos);
      cnt_d += int'(bus.coloca_objetos);
    end
    bus.bordaNovoDestino = 1'b0; bus.fimT = 1'b0;
    check("overrun_once", cnt_a, 1);
    check("registra_once", cnt_b, 1);
    check("tira_once", cnt_c, 1);
    check("coloca_none", cnt_d, 0);

    // a destination edge during MOVE aborts the trip with motors off
    bus.sobe = 1'b1; bus.temDestino = 1'b1;
    tick();
    bus.temDestino = 1'b0;
    tick(); tick();
    check("abort_moving", 32'(bus.motor_sobe), 1);
    bus.bordaNovoDestino = 1'b1;
    tick();
    bus.bordaNovoDestino = 1'b0;
    tick();
    check("abort_ocioso", 32'({bus.db_estado, bus.motor_sobe, bus.motor_desce}), 32'({4'd1, 2'b00}));
    for (int i = 0; i < 10; i++) tick();
    check("abort_end", 32'(bus.db_estado), 1);

    // asynchronous reset while moving up
    bus.temDestino = 1'b1;
    tick();
    bus.temDestino = 1'b0;
    tick(); tick(); tick();
    check("premove_up", 32'(bus.motor_sobe), 1);
    #2 reset = 1'b0;
    #1;
    check("async_outs", 32'(outs()), 0);
    check("async_state", 32'(bus.db_estado), 0);
    tick();
    reset = 1'b1;
    tick(); tick();
    check("move_reset_ocioso", 32'(bus.db_estado), 1);

    // reset in the middle of a scan restarts without a RAM write
    qlen = 99;
    bus.ramSecDifZero = 1'b1;
    bus.bordaNovoDestino = 1'b1;
    tick();
    bus.bordaNovoDestino = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("midscan_busca", 32'(bus.db_estado), 3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    qlen = 0;
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt_a += int'(bus.enableRAM);
    end
    check("midscan_no_ram", cnt_a, 0);
    check("midscan_ocioso", 32'(bus.db_estado), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
